// File: rtl/ws2812_tx.sv
// ws2812_tx: single-wire serial transmitter for a WS2812-class LED chain.
// A frame is a low reset period, NUM_LEDS 24-bit pixels sent MSB first with
// parameterised high/low bit timing, and a low latch period. Pixels arrive
// through a one-entry holding register; a missing pixel ends the frame early
// and raises a sticky underrun flag.
module ws2812_tx #(
  parameter int NUM_LEDS = 36,
  parameter int T0H      = 36,
  parameter int T0L      = 80,
  parameter int T1H      = 70,
  parameter int T1L      = 60,
  parameter int TRST     = 5000,
  parameter int CNT_W    = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [23:0] pix_data,
  input  logic        pix_valid,
  output logic        pix_ready,
  output logic        dout,
  output logic        busy,
  output logic        done,
  output logic        underrun,
  output logic [7:0]  frame_cnt
);

  // Pixel counter only has to reach NUM_LEDS-1.
  localparam int PIX_W = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;

  // Timer load values: a phase of N cycles counts N-1 down to 0.
  localparam logic [CNT_W-1:0] TRST_LD  = CNT_W'(TRST - 1);
  localparam logic [CNT_W-1:0] T0H_LD   = CNT_W'(T0H - 1);
  localparam logic [CNT_W-1:0] T0L_LD   = CNT_W'(T0L - 1);
  localparam logic [CNT_W-1:0] T1H_LD   = CNT_W'(T1H - 1);
  localparam logic [CNT_W-1:0] T1L_LD   = CNT_W'(T1L - 1);
  localparam logic [CNT_W-1:0] TMR_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] TMR_ZERO = CNT_W'(0);
  localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(NUM_LEDS - 1);
  localparam logic [PIX_W-1:0] PIX_ONE  = PIX_W'(1);
  localparam logic [PIX_W-1:0] PIX_ZERO = PIX_W'(0);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RST   = 3'd1,
    S_HIGH  = 3'd2,
    S_LOW   = 3'd3,
    S_LATCH = 3'd4
  } state_e;

  // High-phase timer load for the bit about to be sent.
  function automatic logic [CNT_W-1:0] high_len(input logic b);
    if (b) begin
      high_len = T1H_LD;
    end else begin
      high_len = T0H_LD;
    end
  endfunction

  // Low-phase timer load for the bit currently being sent.
  function automatic logic [CNT_W-1:0] low_len(input logic b);
    if (b) begin
      low_len = T1L_LD;
    end else begin
      low_len = T0L_LD;
    end
  endfunction

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   timer_q, timer_d;
  logic [23:0]        shift_q, shift_d;
  logic [4:0]         bit_idx_q, bit_idx_d;
  logic [PIX_W-1:0]   pix_cnt_q, pix_cnt_d;
  logic [23:0]        hold_q, hold_d;
  logic               hold_full_q, hold_full_d;
  logic               pix_ready_q, pix_ready_d;
  logic               dout_q, dout_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               underrun_q, underrun_d;
  logic [7:0]         frame_cnt_q, frame_cnt_d;
  logic               load_s;
  logic               accept_s;
  logic               timer_zero_s;

  // Frame sequencer: phase timing, bit/pixel stepping and frame bookkeeping.
  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    shift_d      = shift_q;
    bit_idx_d    = bit_idx_q;
    pix_cnt_d    = pix_cnt_q;
    underrun_d   = underrun_q;
    frame_cnt_d  = frame_cnt_q;
    done_d       = 1'b0;
    load_s       = 1'b0;
    timer_zero_s = (timer_q == TMR_ZERO);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RST;
          timer_d = TRST_LD;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_RST: begin
        if (!timer_zero_s) begin
          timer_d = timer_q - TMR_ONE;
        end else if (hold_full_q) begin
          load_s    = 1'b1;
          shift_d   = hold_q;
          pix_cnt_d = PIX_ZERO;
          bit_idx_d = 5'd23;
          state_d   = S_HIGH;
          timer_d   = high_len(hold_q[23]);
        end else begin
          underrun_d = 1'b1;
          state_d    = S_LATCH;
          timer_d    = TRST_LD;
        end
      end

      S_HIGH: begin
        if (!timer_zero_s) begin
          timer_d = timer_q - TMR_ONE;
        end else begin
          state_d = S_LOW;
          timer_d = low_len(shift_q[23]);
        end
      end

      S_LOW: begin
        if (!timer_zero_s) begin
          timer_d = timer_q - TMR_ONE;
        end else if (bit_idx_q != 5'd0) begin
          // Next bit of the same pixel; the shifter keeps the current bit at [23].
          bit_idx_d = bit_idx_q - 5'd1;
          shift_d   = {shift_q[22:0], 1'b0};
          state_d   = S_HIGH;
          timer_d   = high_len(shift_q[22]);
        end else if (pix_cnt_q < LAST_PIX) begin
          if (hold_full_q) begin
            load_s    = 1'b1;
            shift_d   = hold_q;
            pix_cnt_d = pix_cnt_q + PIX_ONE;
            bit_idx_d = 5'd23;
            state_d   = S_HIGH;
            timer_d   = high_len(hold_q[23]);
          end else begin
            // Starved mid-frame: skip the rest of the pixels and latch.
            underrun_d = 1'b1;
            state_d    = S_LATCH;
            timer_d    = TRST_LD;
          end
        end else begin
          state_d = S_LATCH;
          timer_d = TRST_LD;
        end
      end

      S_LATCH: begin
        if (!timer_zero_s) begin
          timer_d = timer_q - TMR_ONE;
        end else begin
          state_d     = S_IDLE;
          done_d      = 1'b1;
          frame_cnt_d = frame_cnt_q + 8'd1;
        end
      end

      default: begin
        state_d = S_IDLE;
        timer_d = TMR_ZERO;
      end
    endcase
  end

  // Holding register: accept when empty, free when loaded into the shifter.
  always_comb begin
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    accept_s    = pix_valid & pix_ready_q;
    if (accept_s) begin
      hold_d      = pix_data;
      hold_full_d = 1'b1;
    end else if (load_s) begin
      hold_full_d = 1'b0;
    end else begin
      hold_full_d = hold_full_q;
    end
  end

  // Output pre-decode from the next state so the registered outputs line up with the state.
  always_comb begin
    dout_d      = (state_d == S_HIGH);
    busy_d      = (state_d != S_IDLE);
    pix_ready_d = ~hold_full_d;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      timer_q     <= TMR_ZERO;
      shift_q     <= 24'd0;
      bit_idx_q   <= 5'd0;
      pix_cnt_q   <= PIX_ZERO;
      hold_q      <= 24'd0;
      hold_full_q <= 1'b0;
      pix_ready_q <= 1'b1;
      dout_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      underrun_q  <= 1'b0;
      frame_cnt_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      shift_q     <= shift_d;
      bit_idx_q   <= bit_idx_d;
      pix_cnt_q   <= pix_cnt_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      pix_ready_q <= pix_ready_d;
      dout_q      <= dout_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      underrun_q  <= underrun_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign pix_ready = pix_ready_q;
  assign dout      = dout_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign underrun  = underrun_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_ws2812_tx.sv
// tb_ws2812_tx: randomized self-checking bench for ws2812_tx.
// The reference model builds the expected line waveform of each frame from
// the pixels the bench handed over, using the bit timing rules directly.
module tb_ws2812_tx;

  localparam int NL = 2, A0H = 2, A0L = 4, A1H = 4, A1L = 2, ART = 10;
  localparam int FNL = 1, F0H = 1, F0L = 2, F1H = 2, F1L = 1, FRT = 3;
  localparam int F_PER = 1 + 2 * FRT + 24 * (F0H + F0L);

  logic        clk = 1'b0;
  logic        reset, start, pix_valid, pix_ready, dout, busy, done, underrun;
  logic [23:0] pix_data;
  logic [7:0]  frame_cnt;
  logic        f_start, f_pix_valid, f_pix_ready, f_dout, f_busy, f_done, f_underrun;
  logic [23:0] f_pix_data;
  logic [7:0]  f_frame_cnt;

  int          n_err, n_chk;
  logic [1:0]  pv_mode;
  logic [23:0] src_q[$];
  logic [23:0] acc_q[$];
  logic        trace[$];

  always #5 clk = ~clk;

  ws2812_tx #(.NUM_LEDS(NL), .T0H(A0H), .T0L(A0L), .T1H(A1H), .T1L(A1L),
              .TRST(ART), .CNT_W(16)) u_dut (
    .clk(clk), .reset(reset), .start(start), .pix_data(pix_data),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .dout(dout), .busy(busy),
    .done(done), .underrun(underrun), .frame_cnt(frame_cnt));

  ws2812_tx #(.NUM_LEDS(FNL), .T0H(F0H), .T0L(F0L), .T1H(F1H), .T1L(F1L),
              .TRST(FRT), .CNT_W(8)) u_fast (
    .clk(clk), .reset(reset), .start(f_start), .pix_data(f_pix_data),
    .pix_valid(f_pix_valid), .pix_ready(f_pix_ready), .dout(f_dout), .busy(f_busy),
    .done(f_done), .underrun(f_underrun), .frame_cnt(f_frame_cnt));

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs (called at a falling edge), log any handshake, wait a cycle.
  task automatic tick(input logic s, input logic r);
    logic v;
    start = s;
    reset = r;
    v = 1'b0;
    if (!r && src_q.size() > 0) begin
      case (pv_mode)
        2'd1:    v = ($urandom_range(0, 3) != 0);
        2'd2:    v = 1'b1;
        default: v = 1'b0;
      endcase
    end
    pix_valid = v;
    pix_data  = (src_q.size() > 0) ? src_q[0] : 24'($urandom);
    if (v && pix_ready) acc_q.push_back(src_q.pop_front());
    @(negedge clk);
  endtask

  // Start a frame, record the line while busy, then compare with the model.
  task automatic run_frame(input int n_exp, input logic exp_under, input logic [7:0] exp_cnt);
    int          done_at, sum, nbad;
    logic        exp_w[$];
    logic [23:0] p;
    trace.delete();
    done_at = -1;
    tick(1'b1, 1'b0);
    for (int c = 1; c <= 4000 && done_at < 0; c++) begin
      if (busy) trace.push_back(dout);
      if (done) begin
        done_at = c;
        check_eq("busy_at_done", busy, 1'b0);
        check_eq("frame_cnt", frame_cnt, exp_cnt);
        check_eq("underrun", underrun, exp_under);
      end else begin
        tick(1'b0, 1'b0);
      end
    end
    // Reference waveform: reset low, each bit as high+low run, latch low.
    sum = 0;
    for (int i = 0; i < ART; i++) exp_w.push_back(1'b0);
    check_eq("pix_avail", (acc_q.size() >= n_exp), 1'b1);
    for (int k = 0; k < n_exp && acc_q.size() > 0; k++) begin
      p = acc_q.pop_front();
      for (int b = 23; b >= 0; b--) begin
        for (int i = 0; i < (p[b] ? A1H : A0H); i++) exp_w.push_back(1'b1);
        for (int i = 0; i < (p[b] ? A1L : A0L); i++) exp_w.push_back(1'b0);
        sum += p[b] ? (A1H + A1L) : (A0H + A0L);
      end
    end
    for (int i = 0; i < ART; i++) exp_w.push_back(1'b0);
    check_eq("done_cycle", done_at, 1 + 2 * ART + sum);
    check_eq("frame_len", trace.size(), exp_w.size());
    nbad = 0;
    for (int i = 0; i < trace.size(); i++)
      if (i >= exp_w.size() || trace[i] !== exp_w[i]) nbad++;
    check_eq("wave_bad_samples", nbad, 0);
    tick(1'b0, 1'b0);
    check_eq("done_one_cycle", done, 1'b0);
  endtask

  initial begin
    int nd, first, last, nbad;
    n_err = 0; n_chk = 0; pv_mode = 2'd2;
    start = 1'b0; pix_valid = 1'b0; pix_data = 24'd0; reset = 1'b1;
    f_start = 1'b0; f_pix_valid = 1'b0; f_pix_data = 24'd0;

    repeat (3) tick(1'b0, 1'b1);
    check_eq("rst_dout", dout, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_done", done, 1'b0);
    check_eq("rst_underrun", underrun, 1'b0);
    check_eq("rst_frame_cnt", frame_cnt, 8'd0);
    check_eq("rst_pix_ready", pix_ready, 1'b1);

    // Directed two-pixel frame.
    src_q = {24'hA50000, 24'h0000FF};
    repeat (3) tick(1'b0, 1'b0);
    run_frame(2, 1'b0, 8'd1);

    // Only one pixel supplied, then a full frame: underrun stays set.
    src_q = {24'($urandom)};
    repeat (2) tick(1'b0, 1'b0);
    run_frame(1, 1'b1, 8'd2);
    src_q = {24'($urandom), 24'($urandom)};
    repeat (2) tick(1'b0, 1'b0);
    run_frame(2, 1'b1, 8'd3);

    // Reset in the middle of a frame.
    src_q = {24'($urandom), 24'($urandom)};
    repeat (2) tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    repeat (29) tick(1'b0, 1'b0);
    tick(1'b0, 1'b1);
    check_eq("mid_rst_dout", dout, 1'b0);
    check_eq("mid_rst_busy", busy, 1'b0);
    check_eq("mid_rst_pix_ready", pix_ready, 1'b1);
    check_eq("mid_rst_underrun", underrun, 1'b0);
    check_eq("mid_rst_frame_cnt", frame_cnt, 8'd0);
    acc_q.delete();
    src_q.delete();
    src_q = {24'($urandom), 24'($urandom)};
    repeat (2) tick(1'b0, 1'b0);
    run_frame(2, 1'b0, 8'd1);

    // Start with nothing to send.
    run_frame(0, 1'b1, 8'd2);

    // Random pixel supply over several frames.
    repeat (2) tick(1'b0, 1'b1);
    acc_q.delete();
    pv_mode = 2'd1;
    repeat (12) src_q.push_back(24'($urandom));
    for (int f = 1; f <= 6; f++) begin
      repeat ($urandom_range(1, 5)) tick(1'b0, 1'b0);
      run_frame(2, 1'b0, 8'(f));
    end

    // Back-to-back frames with start held: 256 frames, counter wraps.
    f_pix_valid = 1'b1;
    f_start = 1'b1;
    nd = 0; first = -1; last = -1; nbad = 0;
    for (int c = 1; c <= 256 * F_PER + 200 && nd < 256; c++) begin
      f_pix_data = 24'($urandom);
      @(negedge clk);
      if (f_done) begin
        if (nd == 0) first = c;
        else if (c - last != F_PER) nbad++;
        last = c;
        nd++;
        if (nd == 255) check_eq("f_cnt_255", f_frame_cnt, 8'd255);
      end
    end
    f_start = 1'b0;
    check_eq("f_frames", nd, 256);
    check_eq("f_first_done", first, F_PER);
    check_eq("f_period_bad", nbad, 0);
    check_eq("f_cnt_wrap", f_frame_cnt, 8'd0);
    check_eq("f_underrun", f_underrun, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
